// File: rtl/lcd_menu_sequencer.sv
// Menu navigation front end for the LCD writer: tracks the selected option and
// streams the 9-word "CLEAR, option <digit>" instruction message per selection.
module lcd_menu_sequencer #(
  parameter int N_OPTIONS      = 4,
  parameter bit START_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  output logic [3:0] option_index,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [8:0] instr_data,
  output logic       busy,
  output logic       msg_done
);

  localparam logic [3:0] LAST_OPT  = 4'(N_OPTIONS - 1);
  localparam logic [3:0] LAST_WORD = 4'd8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_reg, state_next;
  logic [3:0] word_reg, word_next;
  logic [3:0] option_reg, option_next;
  logic [3:0] msg_idx_reg, msg_idx_next;
  logic       pending_reg, pending_next;
  logic       done_reg, done_next;
  logic       nav_next, nav_prev, accept;

  // Bit 8 selects the LCD data register; the last word carries the ASCII digit.
  function automatic logic [8:0] msg_word(input logic [3:0] w, input logic [3:0] idx);
    logic [8:0] word;
    word = 9'h000;
    case (w)
      4'd0:    word = 9'h001;
      4'd1:    word = 9'h16F;
      4'd2:    word = 9'h170;
      4'd3:    word = 9'h174;
      4'd4:    word = 9'h169;
      4'd5:    word = 9'h16F;
      4'd6:    word = 9'h16E;
      4'd7:    word = 9'h120;
      default: word = {1'b1, 8'h31 + {4'h0, idx}};
    endcase
    return word;
  endfunction

  // Simultaneous next/prev pulses cancel each other out.
  assign nav_next = btn_next & ~btn_prev;
  assign nav_prev = btn_prev & ~btn_next;
  assign accept   = nav_next | nav_prev;

  always_comb begin
    option_next = option_reg;
    if (nav_next) begin
      option_next = (option_reg == LAST_OPT) ? 4'd0 : option_reg + 4'd1;
    end else if (nav_prev) begin
      option_next = (option_reg == 4'd0) ? LAST_OPT : option_reg - 4'd1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    word_next    = word_reg;
    pending_next = pending_reg | accept;
    msg_idx_next = msg_idx_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg || accept) begin
          state_next   = SEND;
          word_next    = 4'd0;
          pending_next = 1'b0;
          msg_idx_next = option_next;
        end
      end
      SEND: begin
        if (instr_ready) begin
          if (word_reg == LAST_WORD) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            word_next = word_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      word_reg    <= 4'd0;
      option_reg  <= 4'd0;
      msg_idx_reg <= 4'd0;
      pending_reg <= START_ON_RESET;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      option_reg  <= option_next;
      msg_idx_reg <= msg_idx_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
    end
  end

  assign option_index = option_reg;
  assign instr_valid  = (state_reg == SEND);
  assign busy         = (state_reg == SEND);
  assign instr_data   = (state_reg == SEND) ? msg_word(word_reg, msg_idx_reg) : 9'h000;
  assign msg_done     = done_reg;

endmodule

// File: tb/tb_lcd_menu_sequencer.sv
// Directed bench for lcd_menu_sequencer: expected words queued at stimulus
// time, popped by a negedge monitor as transfers occur.
module tb_lcd_menu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next, btn_prev;
  logic [3:0] option_index;
  logic       instr_valid, instr_ready;
  logic [8:0] instr_data;
  logic       busy, msg_done;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;

  logic [8:0] exp_q[$];
  int         pos       = 0;
  bit         done_exp  = 1'b0;
  bit         hold_flag = 1'b0;
  logic [8:0] hold_data = 9'h000;

  lcd_menu_sequencer #(.N_OPTIONS(4), .START_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .option_index(option_index), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .busy(busy),
    .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int idx);
    logic [8:0] words[9];
    words = '{9'h001, 9'h16F, 9'h170, 9'h174, 9'h169, 9'h16F, 9'h16E, 9'h120, 9'h131};
    words[8] = 9'h131 + 9'(idx);
    for (int i = 0; i < 9; i++) exp_q.push_back(words[i]);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    compared++;
    if (done_cnt < target) begin
      mismatched++;
      $display("FAIL wait_done: observed %0d messages expected %0d within %0d cycles",
               done_cnt, target, budget);
    end
  endtask

  task automatic pulse(input logic nxt, input logic prv);
    btn_next = nxt;
    btn_prev = prv;
    tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
  endtask

  // Monitor: a transfer is committed at the posedge following a negedge that
  // sees valid & ready with reset low.
  always @(negedge clk) begin
    if (reset) begin
      pos       = 0;
      done_exp  = 1'b0;
      hold_flag = 1'b0;
    end else begin
      if (hold_flag) begin
        check("hold_valid", {8'h00, instr_valid}, 9'h001);
        check("hold_data", instr_data, hold_data);
      end
      check("msg_done", {8'h00, msg_done}, {8'h00, done_exp});
      check("busy", {8'h00, busy}, {8'h00, instr_valid});
      done_exp = 1'b0;
      if (msg_done) done_cnt++;
      if (instr_valid && instr_ready) begin
        hold_flag = 1'b0;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: observed %h expected no transfer", instr_data);
        end else begin
          check("word", instr_data, exp_q.pop_front());
        end
        pos++;
        if (pos == 9) begin
          pos      = 0;
          done_exp = 1'b1;
        end
      end else if (instr_valid) begin
        hold_flag = 1'b1;
        hold_data = instr_data;
      end else begin
        hold_flag = 1'b0;
      end
    end
  end

  initial begin
    reset       = 1'b1;
    btn_next    = 1'b0;
    btn_prev    = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", {8'h00, instr_valid}, 9'h000);
    check("rst_data", instr_data, 9'h000);
    check("rst_busy", {8'h00, busy}, 9'h000);
    check("rst_done", {8'h00, msg_done}, 9'h000);
    check("rst_option", {5'h00, option_index}, 9'h000);

    // Automatic start-up message for option 0
    push_msg(0);
    reset = 1'b0;
    wait_done(1, 40);
    check("boot_option", {5'h00, option_index}, 9'h000);
    tick();

    // Four btn_next presses: 1, 2, 3, wrap to 0
    for (int i = 1; i <= 4; i++) begin
      push_msg(i % 4);
      pulse(1'b1, 1'b0);
      check("next_latency", {8'h00, instr_valid}, 9'h001);
      check("next_option", {5'h00, option_index}, 9'(i % 4));
      wait_done(1 + i, 40);
      tick();
    end

    // btn_prev from 0 wraps to 3
    push_msg(3);
    pulse(1'b0, 1'b1);
    check("prev_option", {5'h00, option_index}, 9'h003);
    wait_done(6, 40);
    tick();

    // Two pulses mid-message collapse into one follow-up message
    push_msg(0);
    pulse(1'b1, 1'b0);
    tick(); tick(); tick();
    push_msg(2);
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b0);
    check("mid_option", {5'h00, option_index}, 9'h002);
    wait_done(7, 40);
    check("gap_one_idle", {8'h00, instr_valid}, 9'h001);
    wait_done(8, 40);
    for (int i = 0; i < 15; i++) tick();
    check("no_third_msg", {8'h00, instr_valid}, 9'h000);

    // Pseudo-random backpressure, ~30% ready
    push_msg(3);
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 400 && done_cnt < 9; n++) begin
      instr_ready = ($urandom_range(0, 9) < 3);
      tick();
    end
    instr_ready = 1'b1;
    wait_done(9, 20);
    tick();

    // Simultaneous next+prev while idle: ignored
    pulse(1'b1, 1'b1);
    check("both_option", {5'h00, option_index}, 9'h003);
    check("both_valid", {8'h00, instr_valid}, 9'h000);
    tick(); tick();
    check("both_valid_later", {8'h00, instr_valid}, 9'h000);

    // Reset at word 5 aborts the message; a fresh option-0 message follows
    push_msg(0);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("abort_valid", {8'h00, instr_valid}, 9'h000);
    check("abort_option", {5'h00, option_index}, 9'h000);
    push_msg(0);
    reset = 1'b0;
    wait_done(10, 40);
    for (int i = 0; i < 5; i++) tick();
    check("queue_empty", 9'(exp_q.size()), 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_menu_sequencer.md
Name: lcd_menu_sequencer

Overview:
- Upstream stage of the LCD Avalon-MM writer.
- Turns edge-detected navigation pulses into a selected option index.
- For each selection it streams the 9-word LCD instruction message "CLEAR_DISPLAY, o p t i o n, space, digit" over a valid/ready handshake.
- The downstream writer converts each word into one Avalon-MM write to the LCD controller. Bit 8 of each word becomes the Avalon address bit; bits 7:0 become writedata.

Parameters:
- N_OPTIONS, 4, number of menu options; legal range 1..9, so the digit is always a single ASCII character '1'..'9'.
- START_ON_RESET, 1, when 1 the message for option 0 is sent automatically after reset.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_next  in  1  single-cycle pulse, already edge-detected upstream; advance the option.
- btn_prev  in  1  single-cycle pulse, already edge-detected upstream; go back one option.
- option_index  out  4  current selection, range 0..N_OPTIONS-1.
- instr_valid  out  1  instr_data holds a valid word.
- instr_ready  in  1  downstream writer accepts the word.
- instr_data  out  9  bit 8 = LCD address (0 = command, 1 = data); bits 7:0 = byte.
- busy  out  1  high while a message is in flight.
- msg_done  out  1  one-cycle pulse after the last word of a message has been accepted.

Behaviour:
- Reset values:
  - option_index = 0, instr_valid = 0, instr_data = 0, busy = 0, msg_done = 0.
  - word counter = 0, state = IDLE.
  - pending = START_ON_RESET.
  - Reset asserted mid-message aborts the message: instr_valid is 0 in the cycle after the reset edge, and no partial words are resumed.
- Navigation (evaluated every cycle, in any state):
  - btn_next alone: option_index = (option_index == N_OPTIONS-1) ? 0 : option_index + 1.
  - btn_prev alone: option_index = (option_index == 0) ? N_OPTIONS-1 : option_index - 1.
  - btn_next and btn_prev in the same cycle: option_index unchanged, pending unchanged.
  - Any single accepted pulse sets pending = 1.
- Message content, indexed by the word counter w = 0..8:
  - w0: 9'h001 (CLEAR_DISPLAY).
  - w1..w6: 9'h16F, 9'h170, 9'h174, 9'h169, 9'h16F, 9'h16E ("option").
  - w7: 9'h120 (space).
  - w8: {1'b1, 8'h31 + msg_idx}.
  - msg_idx is latched from option_index (including any same-edge update) at the IDLE->SEND transition. It is not affected by later navigation until the next message starts.
- FSM:
  - IDLE: instr_valid = 0, instr_data = 0, busy = 0.
    - If pending, or a pulse is accepted this cycle: at the next edge go to SEND, set w = 0, clear pending, latch msg_idx.
  - SEND: instr_valid = 1, instr_data = word[w], busy = 1.
    - Transfer happens on an edge where instr_valid & instr_ready.
    - Transfer with w < 8: w <= w + 1.
    - Transfer with w == 8: go to IDLE and assert msg_done for the following cycle.
    - No transfer: w and instr_data are held stable. instr_valid never drops without a transfer, except on reset.
  - A pulse accepted during SEND only sets pending. The current message completes with the old digit.
  - If pending at message end: exactly one IDLE cycle (the msg_done cycle), then SEND with the latest option_index. Multiple pulses during a message collapse into a single follow-up message.
- Latency and throughput:
  - Pulse in IDLE at cycle k: first word valid in cycle k+1.
  - With instr_ready held at 1: 9 consecutive transfers, msg_done in cycle k+10.
  - Minimum gap between messages: 1 idle cycle.
- instr_ready is ignored while instr_valid = 0.

Test Plan:
- Reset release, START_ON_RESET=1, instr_ready=1 -> exactly 9 transfers 001,16F,170,174,169,16F,16E,120,131; msg_done one cycle after the 9th transfer; option_index=0.
- Idle, pulse btn_next -> valid the next cycle; message ends in 9'h132; option_index=1. Then 3 more btn_next pulses (each after msg_done) -> 133, 134, then wrap to 131 with option_index=0.
- Idle at 0, pulse btn_prev -> option_index=3; last word 9'h134.
- instr_ready pseudo-random, about 30% high -> every word held stable while not accepted; 9 words in exact order, none skipped or duplicated.
- During a message (at w=3), pulse btn_next twice -> current message ends with the old digit; one IDLE cycle; one follow-up message with digit for option_index+2; no third message.
- btn_next and btn_prev in the same cycle while idle -> no index change, instr_valid stays 0.
- reset asserted at w=5 with START_ON_RESET=1 -> instr_valid=0 in the cycle after the reset edge; after release a fresh message with digit 9'h131 starts.
